mem_port_arbiter: RTL and testbench

- Shares the single unified memory port (instruction fetch and load/store) between two requesters: the multicycle core (port 0) and a program loader/DMA engine (port 1).
- Arbitrates round-robin and sequences each memory access over a fixed latency.
- Returns read data with a one-cycle done pulse.
- Sits between the requesters and the memory block, driving its address, write-data and read/write strobes.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port
// between the core (port 0) and the loader/DMA (port 1).
module mem_port_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic          core_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          own_q, own_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          mis_q, mis_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          win;
  logic [AW-1:0] addr_sel;

  // State and command registers; reset aborts any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  // Arbitration, command latch and access sequencing.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    own_d    = own_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mis_d    = mis_q;
    rdata_d  = rdata_q;
    win      = (req0 & req1) ? ~last_q : req1;
    addr_sel = win ? addr1 : addr0;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          own_d   = win;
          last_d  = win;
          we_d    = win ? we1 : we0;
          addr_d  = addr_sel;
          wdata_d = win ? wdata1 : wdata0;
          mis_d   = (addr_sel[1:0] != 2'b00);
          cnt_d   = 4'(MEM_LAT - 1);
          state_d = (addr_sel[1:0] != 2'b00) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state and command.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err       = 1'b0;
    busy      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      state_q == ACCESS: begin
        busy      = 1'b1;
        gnt0      = ~own_q;
        gnt1      = own_q;
        mem_read  = ~we_q;
        mem_write = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
      end
      state_q == RESP: begin
        busy  = 1'b1;
        gnt0  = ~own_q;
        gnt1  = own_q;
        done0 = ~own_q;
        done1 = own_q;
        err   = mis_q;
      end
      default: ;
    endcase
    rdata      = rdata_q;
    core_stall = req0 & ~done0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of
// mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, we;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] mem_rdata;
  logic        gnt0, gnt1, done0, done1, err, busy, core_stall;
  logic        mem_read, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req[0]), .we0(we[0]), .addr0(addr[0]), .wdata0(wdata[0]),
    .gnt0(gnt0), .done0(done0),
    .req1(req[1]), .we1(we[1]), .addr1(addr[1]), .wdata1(wdata[1]),
    .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .err(err), .busy(busy), .core_stall(core_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  int checks, failures;

  logic [31:0] env_mem [64];
  logic [31:0] shadow [64];

  bit          m_busy, m_own, m_we, m_mis, m_last;
  int          m_off;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic [1:0]  e_gnt, e_done;
  logic        e_busy, e_err, e_acc, e_rd, e_wr, e_rd_last;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int tlen();
    return m_mis ? 1 : LAT + 1;
  endfunction

  task automatic pre();
    @(negedge clk);
    e_busy    = m_busy;
    e_gnt     = !m_busy ? 2'b00 : (m_own ? 2'b10 : 2'b01);
    e_done    = (m_busy && m_off == tlen()) ? e_gnt : 2'b00;
    e_err     = m_busy && m_mis && m_off == tlen();
    e_acc     = m_busy && !m_mis && m_off <= LAT;
    e_rd      = e_acc && !m_we;
    e_wr      = e_acc && m_we;
    e_rd_last = e_rd && m_off == LAT;
    chk("busy", 64'(busy), 64'(e_busy));
    chk("gnt", 64'({gnt1, gnt0}), 64'(e_gnt));
    chk("done", 64'({done1, done0}), 64'(e_done));
    chk("err", 64'(err), 64'(e_err));
    chk("mem_read", 64'(mem_read), 64'(e_rd));
    chk("mem_write", 64'(mem_write), 64'(e_wr));
    chk("rdata", 64'(rdata), 64'(m_rdata));
    if (e_acc) chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    if (e_wr) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
  endtask

  task automatic post();
    int w;
    #1;
    chk("core_stall", 64'(core_stall), 64'(req[0] & ~e_done[0]));
    if (mem_write) env_mem[mem_addr[7:2]] = mem_wdata;
    mem_rdata = e_rd_last ? env_mem[mem_addr[7:2]] : $urandom;
    if (m_busy && !m_mis && m_we && m_off <= LAT)
      shadow[m_addr[7:2]] = m_wdata;
    if (rst) begin
      m_busy  = 0;
      m_last  = 1;
      m_rdata = '0;
    end else if (m_busy) begin
      if (!m_mis && !m_we && m_off == LAT)
        m_rdata = shadow[m_addr[7:2]];
      if (m_off == tlen()) m_busy = 0;
      else m_off++;
    end else if (req != 2'b00) begin
      if (req == 2'b11) w = m_last ? 0 : 1;
      else w = req[1] ? 1 : 0;
      m_own   = w[0];
      m_last  = w[0];
      m_we    = we[w];
      m_addr  = addr[w];
      m_wdata = wdata[w];
      m_mis   = addr[w][1:0] != 2'b00;
      m_busy  = 1;
      m_off   = 1;
    end
    @(posedge clk);
  endtask

  task automatic xfer(input int p, input bit wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int drop_at, output logic [31:0] rd,
                      output bit er, output bit og);
    int strobes, lat;
    bit mis;
    strobes = 0;
    lat = 0;
    og = 0;
    rd = '0;
    er = 0;
    mis = a[1:0] != 2'b00;
    pre();
    req[p] = 1'b1;
    we[p] = wr;
    addr[p] = a;
    wdata[p] = wd;
    post();
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      pre();
      if (mem_read | mem_write) strobes++;
      if ((p == 0) ? gnt1 : gnt0) og = 1;
      if ((p == 0) ? done0 : done1) begin
        lat = i;
        rd = rdata;
        er = err;
        req[p] = 1'b0;
      end
      if (i == drop_at) req[p] = 1'b0;
      post();
    end
    chk("xfer_latency", 64'(lat), 64'(mis ? 1 : LAT + 1));
    chk("xfer_strobes", 64'(strobes), 64'(mis ? 0 : LAT));
  endtask

  logic [31:0] rd, prev;
  bit          er, og, prev_any;
  int          q[$];

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req = '0;
    we = '0;
    addr[0] = '0; addr[1] = '0;
    wdata[0] = '0; wdata[1] = '0;
    mem_rdata = '0;
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = $urandom;
      shadow[i] = env_mem[i];
    end
    env_mem[4] = 32'hDEADBEEF;
    shadow[4] = 32'hDEADBEEF;
    m_busy = 0; m_last = 1; m_own = 0; m_we = 0; m_mis = 0;
    m_off = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;

    pre(); post();
    pre();
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    rst = 1'b0;
    post();

    xfer(0, 0, 32'h10, 32'h0, 0, rd, er, og);
    chk("rd_dead", 64'(rd), 64'(32'hDEADBEEF));
    chk("rd_dead_err", 64'(er), 64'(0));
    chk("gnt1_never", 64'(og), 64'(0));
    xfer(1, 1, 32'h20, 32'h12345678, 0, rd, er, og);
    chk("wr_err", 64'(er), 64'(0));
    xfer(0, 0, 32'h20, 32'h0, 0, rd, er, og);
    chk("rd_back", 64'(rd), 64'(32'h12345678));
    prev = rdata;
    xfer(0, 0, 32'h6, 32'h0, 0, rd, er, og);
    chk("mis_err", 64'(er), 64'(1));
    chk("mis_rdata", 64'(rd), 64'(prev));
    xfer(0, 0, 32'h10, 32'h0, 2, rd, er, og);
    chk("drop_rd", 64'(rd), 64'(32'hDEADBEEF));

    // fairness after a fresh reset
    pre(); rst = 1'b1; post();
    pre();
    rst = 1'b0;
    req = 2'b11; we = 2'b00;
    addr[0] = 32'h10; addr[1] = 32'h20;
    post();
    prev_any = 0;
    for (int i = 0; i < 60 && q.size() < 4; i++) begin
      pre();
      chk("gnt_excl", 64'(gnt0 & gnt1), 64'(0));
      if ((gnt0 | gnt1) && !prev_any) q.push_back(int'(gnt1));
      prev_any = gnt0 | gnt1;
      post();
    end
    chk("fair_grants", 64'(q.size()), 64'(4));
    for (int k = 0; k < q.size(); k++)
      chk("fair_order", 64'(q[k]), 64'(k % 2));
    req = 2'b00;
    for (int i = 0; i < 20 && m_busy; i++) begin
      pre(); post();
    end

    // reset in the second access cycle
    pre();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    post();
    pre(); post();
    pre();
    rst = 1'b1;
    req = 2'b00;
    post();
    pre();
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_gnt0", 64'(gnt0), 64'(0));
    chk("mid_rst_done", 64'({done1, done0}), 64'(0));
    chk("mid_rst_read", 64'(mem_read), 64'(0));
    chk("mid_rst_rdata", 64'(rdata), 64'(0));
    chk("mid_rst_addr", 64'(mem_addr), 64'(0));
    rst = 1'b0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h20;
    post();
    pre();
    chk("post_rst_gnt1", 64'(gnt1), 64'(1));
    chk("post_rst_gnt0", 64'(gnt0), 64'(0));
    req[1] = 1'b0;
    post();
    for (int i = 0; i < 20 && m_busy; i++) begin
      pre(); post();
    end

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      pre();
      rst = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < 2; p++) begin
        if (m_busy && int'(m_own) == p) begin
          req[p] = ($urandom_range(0, 9) < 7);
          we[p] = $urandom_range(0, 1) != 0;
          addr[p] = $urandom;
          if ($urandom_range(0, 7) != 0) addr[p][1:0] = 2'b00;
          wdata[p] = $urandom;
        end else if (!req[p] && $urandom_range(0, 9) < 4) begin
          req[p] = 1'b1;
          we[p] = $urandom_range(0, 1) != 0;
          addr[p] = $urandom;
          if ($urandom_range(0, 7) != 0) addr[p][1:0] = 2'b00;
          wdata[p] = $urandom;
        end
      end
      post();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
